alu_and_checker: RTL

//   Response-side checker for the ALU bitwise-AND unit. Accepts {a, b, s} vectors

---
 rtl/alu_and_checker.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_and_checker.sv
// Response-side checker for the ALU bitwise-AND unit.
// Takes {a, b, s} vectors seen at the ALU output and compares s against the
// zero-extended a & b. It counts vectors and mismatches for one run, and keeps
// the index and observed s of the first failing vector for readback.
module alu_and_checker #(
  parameter int W     = 3,
  parameter int RW    = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] exp_cnt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [RW-1:0]    in_s,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [RW-1:0]    first_fail_s,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_exp;
  logic [CNT_W-1:0] r_acc;

  logic             r_s1_v;
  logic [W-1:0]     r_s1_a;
  logic [W-1:0]     r_s1_b;
  logic [RW-1:0]    r_s1_s;
  logic             r_s2_v;
  logic [W-1:0]     r_s2_a;
  logic [W-1:0]     r_s2_b;
  logic [RW-1:0]    r_s2_s;

  logic             w_xfer;
  logic             w_start_ok;
  logic [RW-1:0]    w_golden;
  logic             w_fail;

  // A start is honoured only while no run is in progress.
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign in_ready   = (r_state == ST_RUN) && (r_acc < r_exp);
  assign w_xfer     = in_valid && in_ready;

  // Golden result: a & b zero-extended to the result width; all RW bits compared.
  assign w_golden = RW'(r_s2_a & r_s2_b);
  assign w_fail   = r_s2_v && (r_s2_s != w_golden);

  assign done = (r_state == ST_DONE);
  assign pass = done && (err_cnt == '0);

  // State register.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // sample the pre-edge values of each other, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic. DRAIN ends when S1 is empty, so DONE lands on the same
  // edge that commits the final S2 compare.
  // NOTE: the default assignment first keeps this block from inferring a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start)            w_next_state = ST_RUN;
      ST_RUN:   if (r_acc == r_exp)   w_next_state = ST_DRAIN;
      ST_DRAIN: if (!r_s1_v)          w_next_state = ST_DONE;
      ST_DONE:  if (start)            w_next_state = ST_RUN;
      default:                        w_next_state = ST_IDLE;
    endcase
  end

  // Run bookkeeping: expected count latched on start, accepted vectors counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp <= '0;
      r_acc <= '0;
    end else if (w_start_ok) begin
      r_exp <= exp_cnt;
      r_acc <= '0;
    end else if (w_xfer) begin
      r_acc <= r_acc + CNT_W'(1);
    end
  end

  // Pipeline valid bits; these alone decide whether a stage holds a vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
    end else begin
      r_s1_v <= w_xfer;
      r_s2_v <= r_s1_v;
    end
  end

  // Pipeline payload: S1 captures on transfer, S2 takes S1 when it is valid.
  // NOTE: the payload registers have no reset; they are only looked at when
  // the matching valid bit, which is reset, says they hold a vector.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_s1_a <= in_a;
      r_s1_b <= in_b;
      r_s1_s <= in_s;
    end
    if (r_s1_v) begin
      r_s2_a <= r_s1_a;
      r_s2_b <= r_s1_b;
      r_s2_s <= r_s1_s;
    end
  end

  // Results: counters, mismatch pulse and first-failure capture from S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch       <= 1'b0;
      vec_cnt        <= '0;
      err_cnt        <= '0;
      first_fail_idx <= '0;
      first_fail_s   <= '0;
    end else if (w_start_ok) begin
      mismatch       <= 1'b0;
      vec_cnt        <= '0;
      err_cnt        <= '0;
      first_fail_idx <= '0;
      first_fail_s   <= '0;
    end else begin
      mismatch <= w_fail;
      if (r_s2_v) vec_cnt <= vec_cnt + CNT_W'(1);
      if (w_fail) begin
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        if (err_cnt == '0) begin
          first_fail_idx <= vec_cnt;
          first_fail_s   <= r_s2_s;
        end
      end
    end
  end

endmodule
